// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD up/down counter and its segment decoder.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] FND_0     = 7'h3F;
   localparam logic [6:0] FND_1     = 7'h06;
   localparam logic [6:0] FND_2     = 7'h5B;
   localparam logic [6:0] FND_3     = 7'h4F;
   localparam logic [6:0] FND_4     = 7'h66;
   localparam logic [6:0] FND_5     = 7'h6D;
   localparam logic [6:0] FND_6     = 7'h7D;
   localparam logic [6:0] FND_7     = 7'h07;
   localparam logic [6:0] FND_8     = 7'h7F;
   localparam logic [6:0] FND_9     = 7'h6F;
   localparam logic [6:0] FND_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_fnd.sv
// Single-digit BCD to seven-segment decoder; output polarity set by FND_ACT_LOW.
module bcd_to_fnd
   import bcd_pkg::*;
#(
   parameter int unsigned FND_ACT_LOW = 1
) (
   input  bcd_digit_t i_Digit,
   output logic [6:0] o_Seg
);

   logic [6:0] w_seg;

   // Active-high pattern lookup; codes 10..15 blank
   always_comb begin
      w_seg = FND_BLANK;
      case (i_Digit)
         4'd0:    w_seg = FND_0;
         4'd1:    w_seg = FND_1;
         4'd2:    w_seg = FND_2;
         4'd3:    w_seg = FND_3;
         4'd4:    w_seg = FND_4;
         4'd5:    w_seg = FND_5;
         4'd6:    w_seg = FND_6;
         4'd7:    w_seg = FND_7;
         4'd8:    w_seg = FND_8;
         4'd9:    w_seg = FND_9;
         default: w_seg = FND_BLANK;
      endcase
   end

   assign o_Seg = (FND_ACT_LOW != 0) ? ~w_seg : w_seg;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter driven by two active-low push buttons.
// Optional feature: define BCD_CNT_SAT_EN to saturate at all-9 / all-0 instead of wrapping.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS      = 2,
   parameter int unsigned FND_ACT_LOW = 1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [1:0]            i_Push,
   output logic [4*DIGITS-1:0]   o_BCD,
   output logic [3:0]            o_LED,
   output logic [7*DIGITS-1:0]   o_FND,
   output logic [1:0]            o_Carry
);

   logic [1:0]          r_s1, r_s2, r_s3;
   logic                r_live;
   logic [4*DIGITS-1:0] r_bcd;
   logic [1:0]          r_carry;

   logic                w_up, w_dn, w_inc, w_dec;
   logic [DIGITS:0]     w_cy, w_bw;
   logic [4*DIGITS-1:0] w_bcd_up, w_bcd_dn, w_bcd_nxt;
   logic [1:0]          w_carry_nxt;

   // Two-flop synchroniser plus history flop. The first edge after reset fills all three
   // stages from the pin, so a button held through reset release yields no event.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_s1   <= 2'b11;
         r_s2   <= 2'b11;
         r_s3   <= 2'b11;
         r_live <= 1'b0;
      end else if (!r_live) begin
         r_s1   <= i_Push;
         r_s2   <= i_Push;
         r_s3   <= i_Push;
         r_live <= 1'b1;
      end else begin
         r_s1 <= i_Push;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Falling edge of the synchronised button is a press
   assign w_up  = r_s3[1] & ~r_s2[1];
   assign w_dn  = r_s3[0] & ~r_s2[0];
   assign w_inc = w_up & ~w_dn;
   assign w_dec = w_dn & ~w_up;

   assign w_cy[0] = w_inc;
   assign w_bw[0] = w_dec;

   // Per-digit ripple increment/decrement and segment decode
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_t w_dig;
      assign w_dig = r_bcd[4*g +: 4];

      assign w_bcd_up[4*g +: 4] = !w_cy[g] ? w_dig :
                                  (w_dig == BCD_MAX) ? 4'd0 : w_dig + 4'd1;
      assign w_bcd_dn[4*g +: 4] = !w_bw[g] ? w_dig :
                                  (w_dig == 4'd0) ? BCD_MAX : w_dig - 4'd1;
      assign w_cy[g+1] = w_cy[g] & (w_dig == BCD_MAX);
      assign w_bw[g+1] = w_bw[g] & (w_dig == 4'd0);

      bcd_to_fnd #(
         .FND_ACT_LOW (FND_ACT_LOW)
      ) u_fnd (
         .i_Digit (w_dig),
         .o_Seg   (o_FND[7*g +: 7])
      );
   end

   // Next count and active-low wrap pulses; a carry out of the top digit marks a wrap
   always_comb begin
      w_bcd_nxt   = r_bcd;
      w_carry_nxt = 2'b11;
`ifdef BCD_CNT_SAT_EN
      if (w_inc && !w_cy[DIGITS]) begin
         w_bcd_nxt = w_bcd_up;
      end else if (w_dec && !w_bw[DIGITS]) begin
         w_bcd_nxt = w_bcd_dn;
      end
`else
      if (w_inc) begin
         w_bcd_nxt = w_bcd_up;
      end else if (w_dec) begin
         w_bcd_nxt = w_bcd_dn;
      end
      w_carry_nxt = {~w_cy[DIGITS], ~w_bw[DIGITS]};
`endif
   end

   // Count and carry registers
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_bcd   <= '0;
         r_carry <= 2'b11;
      end else begin
         r_bcd   <= w_bcd_nxt;
         r_carry <= w_carry_nxt;
      end
   end

   assign o_BCD   = r_bcd;
   assign o_LED   = r_bcd[3:0];
   assign o_Carry = r_carry;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS = 2, active-low segments).
module tb_bcd_updown_counter;
   import bcd_pkg::*;

   localparam int unsigned DIGITS = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          push = 2'b11;
   logic [4*DIGITS-1:0] bcd;
   logic [3:0]          led;
   logic [7*DIGITS-1:0] fnd;
   logic [1:0]          carry;
   bcd_digit_t          dec_in = 4'd0;
   logic [6:0]          dec_seg;

   int n_chk  = 0;
   int n_pass = 0;

   bcd_updown_counter #(
      .DIGITS      (DIGITS),
      .FND_ACT_LOW (1)
   ) u_dut (
      .i_Clk   (clk),
      .i_Rst   (rst_n),
      .i_Push  (push),
      .o_BCD   (bcd),
      .o_LED   (led),
      .o_FND   (fnd),
      .o_Carry (carry)
   );

   // Stand-alone active-high decoder
   bcd_to_fnd #(
      .FND_ACT_LOW (0)
   ) u_dec_hi (
      .i_Digit (dec_in),
      .o_Seg   (dec_seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // btn bit set = button pressed ([1] up, [0] down)
   task automatic press(input logic [1:0] btn, input int hold);
      @(negedge clk);
      push = ~btn;
      repeat (hold) @(negedge clk);
      push = 2'b11;
      repeat (3) @(negedge clk);
   endtask

   // Press with cycle-exact checks of count latency and carry pulse width
   task automatic press_timed(input string tag, input logic [1:0] btn,
                              input logic [7:0] old_bcd, input logic [7:0] exp_bcd,
                              input logic [1:0] exp_carry);
      @(negedge clk);
      push = ~btn;
      @(posedge clk); #1;
      chk({tag, "_k0"}, bcd, old_bcd);
      @(posedge clk); #1;
      chk({tag, "_k1"}, bcd, old_bcd);
      chk({tag, "_k1_carry"}, carry, 2'b11);
      @(posedge clk); #1;
      chk({tag, "_k2"}, bcd, exp_bcd);
      chk({tag, "_k2_carry"}, carry, exp_carry);
      @(posedge clk); #1;
      chk({tag, "_k3_carry"}, carry, 2'b11);
      repeat (6) @(negedge clk);
      chk({tag, "_held"}, bcd, exp_bcd);
      push = 2'b11;
      repeat (3) @(negedge clk);
      chk({tag, "_released"}, bcd, exp_bcd);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_bcd", bcd, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset with both buttons held
      push  = 2'b00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bcd", bcd, 8'h00);
      chk("rst_led", led, 4'h0);
      chk("rst_carry", carry, 2'b11);
      chk("rst_fnd", fnd, {7'h40, 7'h40});
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_release_held", bcd, 8'h00);
      push = 2'b11;
      repeat (3) @(negedge clk);
      chk("rst_release_up", bcd, 8'h00);

      // Single up press, exact latency
      press_timed("single_up", 2'b10, 8'h00, 8'h01, 2'b11);

      // Ripple carry 09 -> 10, then borrow 10 -> 09
      repeat (8) press(2'b10, 4);
      chk("cnt_09", bcd, 8'h09);
      chk("led_9", led, 4'h9);
      press(2'b10, 4);
      chk("cnt_10", bcd, 8'h10);
      chk("fnd_10", fnd, {7'h79, 7'h40});
      press(2'b01, 4);
      chk("cnt_10_dn", bcd, 8'h09);
      chk("fnd_09", fnd, {7'h40, 7'h10});

      // Climb to 99 and step past it
      repeat (90) press(2'b10, 4);
      chk("cnt_99", bcd, 8'h99);
      chk("fnd_99", fnd, {7'h10, 7'h10});
`ifdef BCD_CNT_SAT_EN
      press_timed("ovf", 2'b10, 8'h99, 8'h99, 2'b11);
`else
      press_timed("ovf", 2'b10, 8'h99, 8'h00, 2'b01);
`endif

      // Underflow from 00
      async_reset();
`ifdef BCD_CNT_SAT_EN
      press_timed("unf", 2'b01, 8'h00, 8'h00, 2'b11);
`else
      press_timed("unf", 2'b01, 8'h00, 8'h99, 2'b10);
`endif

      // Both buttons falling together at 42
      async_reset();
      repeat (42) press(2'b10, 4);
      chk("cnt_42", bcd, 8'h42);
      @(negedge clk);
      push = 2'b00;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("both_bcd", bcd, 8'h42);
         chk("both_carry", carry, 2'b11);
      end
      push = 2'b11;
      repeat (3) @(negedge clk);
      chk("both_after", bcd, 8'h42);

      // Reset mid-press: immediate clear, held button ignored after release
      @(negedge clk);
      push = 2'b01;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_bcd", bcd, 8'h00);
      chk("midrst_led", led, 4'h0);
      chk("midrst_carry", carry, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_held", bcd, 8'h00);
      push = 2'b11;
      repeat (3) @(negedge clk);
      press(2'b10, 4);
      chk("midrst_fresh", bcd, 8'h01);

      // Active-high decoder
      dec_in = 4'd8;
      #1 chk("dec_hi_8", dec_seg, 7'h7F);
      dec_in = 4'd0;
      #1 chk("dec_hi_0", dec_seg, 7'h3F);
      dec_in = 4'd7;
      #1 chk("dec_hi_7", dec_seg, 7'h07);
      dec_in = 4'd12;
      #1 chk("dec_hi_blank", dec_seg, 7'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
